vpp_measure: RTL and testbench

- Peak-to-peak extraction stage directly upstream of the modulation-depth calculator.
- Tracks max/min of the ADC sample stream over fixed windows of WIN_LEN valid samples.
- Averages 2^AVG_SHIFT consecutive window results and presents an unsigned N-bit vpp with a one-cycle valid strobe.
- Runs continuously, with no dropped samples between windows, while enabled.

---
 rtl/vpp_measure.sv | 95 +++++++++
 tb/tb_vpp_measure.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vpp_measure.sv
// vpp_measure: windowed peak-to-peak tracker with power-of-two averaging of window results
module vpp_measure #(
  parameter int N         = 8,
  parameter int WIN_LEN   = 4096,
  parameter int AVG_SHIFT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         measure_enable,
  input  logic [N-1:0] adc_data,
  input  logic         adc_valid,
  output logic [N-1:0] vpp,
  output logic         vpp_valid,
  output logic         busy
);
  localparam int CW = $clog2(WIN_LEN);
  localparam int AW = N + AVG_SHIFT;
  localparam int WW = AVG_SHIFT + 1;
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(WIN_LEN - 1);
  localparam logic [WW-1:0] LAST_WIN = WW'((1 << AVG_SHIFT) - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, next_state;
  logic [N-1:0] max_r, min_r, snap_max, snap_min, diff, cur_max, cur_min;
  logic [CW-1:0] sample_cnt;
  logic [WW-1:0] win_cnt;
  logic [AW-1:0] acc, acc_sum;
  logic s1_v, s2_v, start, run, take, close, emit;
  // Next state plus control strobes; dropping enable overrides everything in RUN
  always_comb begin
    next_state = measure_enable ? RUN : IDLE;
    start      = (state == IDLE) && measure_enable;
    run        = (state == RUN) && measure_enable;
    take       = run && adc_valid;
    close      = take && (sample_cnt == LAST_SAMPLE);
    emit       = run && s2_v && (win_cnt == LAST_WIN);
    cur_max    = (adc_data > max_r) ? adc_data : max_r;
    cur_min    = (adc_data < min_r) ? adc_data : min_r;
    acc_sum    = acc + AW'(diff);
    busy       = (state == RUN);
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  // Running extremes; window close reloads in the same edge so no sample is lost
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      max_r      <= '0;
      min_r      <= '1;
      sample_cnt <= '0;
    end else if (start || close) begin
      max_r      <= '0;
      min_r      <= '1;
      sample_cnt <= '0;
    end else if (take) begin
      max_r      <= cur_max;
      min_r      <= cur_min;
      sample_cnt <= sample_cnt + CW'(1);
    end
  // Snapshot (including the closing sample) then difference; valids die on abort
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      snap_max <= '0;
      snap_min <= '0;
      diff     <= '0;
    end else begin
      s1_v <= close;
      s2_v <= run && s1_v;
      if (close) begin
        snap_max <= cur_max;
        snap_min <= cur_min;
      end
      if (s1_v) diff <= snap_max - snap_min;
    end
  // Accumulate window results; the last one of a group is folded in directly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc       <= '0;
      win_cnt   <= '0;
      vpp       <= '0;
      vpp_valid <= 1'b0;
    end else begin
      vpp_valid <= emit;
      if (emit) vpp <= N'(acc_sum >> AVG_SHIFT);
      if (start) begin
        acc     <= '0;
        win_cnt <= '0;
      end else if (run && s2_v) begin
        acc     <= (win_cnt == LAST_WIN) ? '0 : acc_sum;
        win_cnt <= (win_cnt == LAST_WIN) ? '0 : win_cnt + WW'(1);
      end
    end
endmodule

// File: tb/tb_vpp_measure.sv
// tb_vpp_measure: table, corner-sequence and random checks of vpp_measure against a window/average model
module tb_vpp_measure;
  localparam int WL = 16;
  typedef struct {int cyc; int val;} ev_t;
  typedef struct {int pa; int a; int pb; int b; int exp_pp; int exp_avg;} row_t;
  logic clk = 0, rst_n = 1, en = 0, av = 0;
  logic [7:0] ad = 0;
  logic [7:0] vpp_o [2];
  logic vv_o [2];
  logic busy_o [2];
  int checks = 0, failures = 0, cyc = 0;
  bit mrun = 0;
  int win [$];
  int gsum [2], gcnt [2], vhold [2];
  int sh [2] = '{2, 0};
  ev_t evq [2][$];
  ev_t plog [2][$];
  row_t tbl [12];

  always #5 clk = ~clk;

  vpp_measure #(.N(8), .WIN_LEN(WL), .AVG_SHIFT(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .measure_enable(en), .adc_data(ad), .adc_valid(av),
    .vpp(vpp_o[0]), .vpp_valid(vv_o[0]), .busy(busy_o[0]));
  vpp_measure #(.N(8), .WIN_LEN(WL), .AVG_SHIFT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .measure_enable(en), .adc_data(ad), .adc_valid(av),
    .vpp(vpp_o[1]), .vpp_valid(vv_o[1]), .busy(busy_o[1]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    mrun = 0;
    win.delete();
    gsum = '{0, 0};
    gcnt = '{0, 0};
    vhold = '{0, 0};
    evq[0].delete();
    evq[1].delete();
  endfunction

  // Reference: collect WL accepted samples, take max-min, average groups of 2^sh, result 2 edges later
  function automatic void model_edge();
    int mx, mn;
    ev_t e;
    cyc++;
    if (!rst_n) return;
    if (!mrun) begin
      if (en) begin
        mrun = 1;
        win.delete();
        gsum = '{0, 0};
        gcnt = '{0, 0};
      end
    end else if (!en) begin
      mrun = 0;
      win.delete();
      gsum = '{0, 0};
      gcnt = '{0, 0};
      for (int k = 0; k < 2; k++)
        while (evq[k].size() > 0 && evq[k][$].cyc >= cyc) void'(evq[k].pop_back());
    end else if (av) begin
      win.push_back(int'(ad));
      if (win.size() == WL) begin
        mx = 0;
        mn = 255;
        foreach (win[i]) begin
          if (win[i] > mx) mx = win[i];
          if (win[i] < mn) mn = win[i];
        end
        win.delete();
        for (int k = 0; k < 2; k++) begin
          gsum[k] += mx - mn;
          gcnt[k]++;
          if (gcnt[k] == (1 << sh[k])) begin
            e.cyc = cyc + 2;
            e.val = gsum[k] >> sh[k];
            evq[k].push_back(e);
            gsum[k] = 0;
            gcnt[k] = 0;
          end
        end
      end
    end
  endfunction

  task automatic step(input bit e, input int d, input bit v);
    en = e;
    ad = 8'(d);
    av = v;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Every cycle: outputs against the model, and log real pulses for sequence checks
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit ev;
      ev = (evq[k].size() > 0) && (evq[k][0].cyc == cyc);
      if (ev) begin
        vhold[k] = evq[k][0].val;
        void'(evq[k].pop_front());
      end
      check($sformatf("vpp_valid%0d", k), int'(vv_o[k]), int'(ev));
      check($sformatf("vpp%0d", k), int'(vpp_o[k]), vhold[k]);
      check($sformatf("busy%0d", k), int'(busy_o[k]), int'(mrun));
      if (vv_o[k]) begin
        ev_t p;
        p.cyc = cyc;
        p.val = int'(vpp_o[k]);
        plog[k].push_back(p);
      end
    end
  end

  initial begin
    int d, n, e_last0, e_last1, nv;
    bit ren;
    tbl[0]  = '{3, 0, 9, 255, 255, -1};
    tbl[1]  = '{3, 128, 9, 128, 0, -1};
    tbl[2]  = '{3, 20, 9, 220, 200, -1};
    tbl[3]  = '{3, 200, 9, 100, 100, 138};
    tbl[4]  = '{3, 28, 9, 128, 100, -1};
    tbl[5]  = '{3, 128, 9, 229, 101, -1};
    tbl[6]  = '{3, 26, 9, 128, 102, -1};
    tbl[7]  = '{3, 128, 9, 232, 104, 101};
    tbl[8]  = '{15, 255, 15, 255, 127, -1};
    tbl[9]  = '{0, 0, 0, 0, 128, -1};
    tbl[10] = '{0, 128, 0, 128, 0, -1};
    tbl[11] = '{0, 128, 0, 128, 0, 63};
    model_reset();
    #1 rst_n = 0;
    #1;
    check("rst_vpp", int'(vpp_o[0]), 0);
    check("rst_vpp_valid", int'(vv_o[0]), 0);
    check("rst_busy", int'(busy_o[0]), 0);
    repeat (2) step(0, 0, 0);
    rst_n = 1;
    repeat (2) step(0, 0, 0);
    step(1, 5, 1);
    plog[0].delete();
    plog[1].delete();
    foreach (tbl[i])
      for (int j = 0; j < WL; j++) begin
        d = (j == tbl[i].pa) ? tbl[i].a : (j == tbl[i].pb) ? tbl[i].b : 128;
        step(1, d, 1);
      end
    repeat (3) step(1, 0, 0);
    check("tbl_pulses_avg0", plog[1].size(), 12);
    foreach (tbl[i]) if (i < plog[1].size()) check($sformatf("tbl_pp_row%0d", i), plog[1][i].val, tbl[i].exp_pp);
    check("tbl_pulses_avg4", plog[0].size(), 3);
    n = 0;
    foreach (tbl[i])
      if (tbl[i].exp_avg >= 0) begin
        if (n < plog[0].size()) check($sformatf("tbl_avg_row%0d", i), plog[0][n].val, tbl[i].exp_avg);
        n++;
      end
    plog[0].delete();
    plog[1].delete();
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < WL; j++) step(1, (j <= 8) ? 20 + 25 * j : 220 - 25 * (j - 8), 1);
    repeat (3) step(1, 0, 0);
    check("tri_pulses_avg4", plog[0].size(), 2);
    check("tri_pulses_avg0", plog[1].size(), 8);
    foreach (plog[0][i]) check("tri_vpp", plog[0][i].val, 200);
    if (plog[0].size() == 2) check("tri_spacing", plog[0][1].cyc - plog[0][0].cyc, 4 * WL);
    plog[0].delete();
    plog[1].delete();
    for (int j = 0; j < 10; j++) begin
      step(1, $urandom_range(0, 255), 1);
      step(1, 0, 0);
    end
    repeat (3) step(0, $urandom_range(0, 255), 1);
    check("abort_hold", int'(vpp_o[0]), 200);
    check("abort_no_pulse", plog[0].size() + plog[1].size(), 0);
    step(1, 7, 1);
    e_last0 = 0;
    e_last1 = 0;
    for (int j = 0; j < 4 * WL; j++) begin
      step(1, $urandom_range(0, 255), 1);
      if (j == WL - 1) e_last1 = cyc;
      e_last0 = cyc;
      step(1, $urandom_range(0, 255), 0);
    end
    repeat (3) step(1, 0, 0);
    check("restart_pulses_avg4", plog[0].size(), 1);
    if (plog[0].size() > 0) check("restart_latency_avg4", plog[0][0].cyc, e_last0 + 2);
    if (plog[1].size() > 0) check("restart_latency_avg0", plog[1][0].cyc, e_last1 + 2);
    for (int j = 0; j < 20; j++) step(1, $urandom_range(0, 255), 1);
    #2 rst_n = 0;
    #1;
    check("midrst_vpp", int'(vpp_o[0]), 0);
    check("midrst_vpp_valid", int'(vv_o[0]), 0);
    check("midrst_busy", int'(busy_o[0]), 0);
    model_reset();
    repeat (2) step(1, 0, 0);
    rst_n = 1;
    plog[0].delete();
    step(1, 9, 1);
    for (int j = 0; j < 4 * WL; j++) step(1, $urandom_range(0, 255), 1);
    e_last0 = cyc;
    repeat (3) step(1, 0, 0);
    check("midrst_pulses", plog[0].size(), 1);
    if (plog[0].size() > 0) check("midrst_latency", plog[0][0].cyc, e_last0 + 2);
    ren = 1;
    nv = 0;
    repeat (3000) begin
      ren = ren ? ($urandom_range(0, 399) != 0) : ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 9) == 0) ? 255 * $urandom_range(0, 1) : $urandom_range(0, 255);
      step(ren, d, $urandom_range(0, 3) != 0);
      nv++;
    end
    repeat (4) step(1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
